// File: rtl/alu_exec.sv
// alu_exec -- multi-cycle execute-stage ALU with valid/ready handshakes.
//
// Accepts one request (op code + two operands) when idle. ADD, SUB, XOR,
// AND, SLT and illegal codes finish in one cycle. SRL/SLL shift one bit per
// cycle, so the pipeline can stall on them through in_ready/out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (state == IDLE)
//   operation  6-bit op code: 27 ADD, 28 SUB, 29 SRL, 30 SLL, 31 XOR,
//              32 AND, 33 SLT; anything else is illegal
//   src_a      operand A (value shifted for SRL/SLL)
//   src_b      operand B (low log2(WIDTH) bits are the shift amount)
//   out_valid  result present (state == DONE)
//   out_ready  consumer takes the result
//   result     registered result
//   zero       registered, result == 0
//   illegal    registered, op code was not 27..33
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       operation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD = 6'd27;
    localparam logic [5:0] OP_SUB = 6'd28;
    localparam logic [5:0] OP_SRL = 6'd29;
    localparam logic [5:0] OP_SLL = 6'd30;
    localparam logic [5:0] OP_XOR = 6'd31;
    localparam logic [5:0] OP_AND = 6'd32;
    localparam logic [5:0] OP_SLT = 6'd33;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   cnt;
    logic             shl;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ill;
    logic                    is_shift;
    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        shift_nxt;

    // One-bit logical shift step; zero fill on the vacated end.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input logic left);
        if (left)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign sa    = src_a;
    assign sb    = src_b;
    assign shamt = src_b[SHW-1:0];

    // Single-cycle result; a zero shift amount falls through as src_a.
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (operation)
            OP_ADD: alu_res = src_a + src_b;
            OP_SUB: alu_res = src_a - src_b;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_AND: alu_res = src_a & src_b;
            OP_SLT: alu_res = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_SRL, OP_SLL: begin
                alu_res  = src_a;
                is_shift = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    assign shift_nxt = shift_step(shreg, shl);

    // Shift register holds data only and is always loaded before use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid)
            shreg <= src_a;
        else if (state == S_SHIFT)
            shreg <= shift_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            cnt     <= '0;
            shl     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_shift && shamt != '0) begin
                            cnt   <= shamt;
                            shl   <= (operation == OP_SLL);
                            state <= S_SHIFT;
                        end else begin
                            result  <= alu_res;
                            zero    <= (alu_res == '0);
                            illegal <= alu_ill;
                            state   <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt - CNT_ONE;
                    // Last step: publish the shifted value directly.
                    if (cnt == CNT_ONE) begin
                        result  <= shift_nxt;
                        zero    <= (shift_nxt == '0);
                        illegal <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute-stage ALU that consumes the 6-bit operation code produced by the ALU control decoder and performs the operation on two operands. It sits between the ID/EX register and the EX/MEM register. It uses a valid/ready handshake on both sides, so the pipeline hazard logic can stall on iterative shifts. ADD, SUB, XOR, AND and SLT complete in one cycle; SRL and SLL shift one bit per cycle.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8; shift amount uses low log2(WIDTH) bits of src_b
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- operation  in  6  op code: 27 ADD, 28 SUB, 29 SRL, 30 SLL, 31 XOR, 32 AND, 33 SLT; any other value is illegal
- src_a  in  WIDTH  operand A (value shifted for SRL/SLL)
- src_b  in  WIDTH  operand B (shift amount for SRL/SLL)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  registered, result == 0 (beq uses SUB)
- illegal  out  1  registered, op code was not 27–33

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept happens on a rising edge with in_valid && in_ready. operation, src_a and src_b are sampled only at accept; later changes are ignored.
- Accept of ADD, SUB, XOR, AND or SLT:
  - result loaded the same edge; IDLE→DONE.
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT is signed two's-complement: result = 1 if src_a < src_b, else 0.
- Accept of SRL/SLL, shamt = src_b[log2(WIDTH)-1:0]:
  - shamt == 0: result = src_a; IDLE→DONE.
  - shamt > 0: shift register ← src_a, counter ← shamt; IDLE→SHIFT.
  - In SHIFT, each edge shifts one bit (SRL logical: zero fill at MSB; SLL: zero fill at LSB) and decrements the counter.
  - The edge where the counter goes 1→0 writes the shifted value to result; SHIFT→DONE.
- Accept of an illegal code: result = 0, illegal = 1; IDLE→DONE. illegal = 0 for all legal ops.
- zero is updated with every result load.
- DONE: result, zero and illegal are held stable until an edge with out_ready = 1; then DONE→IDLE. out_ready is ignored outside DONE.
- No overlap: a new request cannot be accepted in the cycle its predecessor retires. Peak throughput is one op per 2 cycles.
- Reset (rst_n = 0 at an edge), valid in any state including mid-SHIFT or DONE:
  - state = IDLE; out_valid = 0; result = 0; zero = 0; illegal = 0; counter = 0.
  - An in-flight op is discarded and produces no output.
  - in_ready = 1 in the first cycle after reset is released.

## Timing
- Latency is counted from the accept edge to the first cycle with out_valid high.
  - Single-cycle op, illegal op, or shift with shamt = 0: out_valid high in the cycle after the accept edge.
  - Shift with shamt = n > 0: out_valid high after n more edges (n+1 cycles after the accept cycle). For WIDTH = 32 the maximum is 32 cycles.
- in_ready is low from the cycle after accept until the cycle after the retire edge.
- All outputs are registered; no combinational path from inputs to outputs except in_ready/out_valid, which decode state only.

## Test plan
- ADD: src_a = 0x7FFFFFFF, src_b = 1 → next cycle result = 0x80000000, zero = 0, illegal = 0. SUB: 5 − 5 → result = 0, zero = 1.
- SLT signed: src_a = 0xFFFFFFFF (−1), src_b = 1 → result = 1. Swap operands → result = 0.
- SLL: src_a = 0x00000001, src_b = 31 → out_valid first high 32 cycles after accept, result = 0x80000000. SRL: src_a = 0x80000000, src_b = 4 → result = 0x08000000 after 5 cycles. shamt 0 → result = src_a after 1 cycle.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → result stable and in_ready = 0 throughout, including while in_valid = 1; raise out_ready → IDLE next cycle, new request accepted.
- operation = 6'd0 → result = 0, illegal = 1, zero = 1, after 1 cycle. Then XOR 0xF0F0F0F0 ^ 0xFFFF0000 → result = 0x0F0FF0F0, illegal = 0.
- Drive rst_n = 0 for one edge during SHIFT (shamt = 20, 5 cycles in) → out_valid never asserts for that op; result = 0; in_ready = 1 the cycle after release.
